process1_monitor_ctrl: RTL and testbench

Measurement controller for process monitor 1. It drives the monitor's enable, target and ring-oscillator select inputs, and waits for the monitor's valid handshake. It then captures the per-monitor counts, evaluates them against low/high thresholds, and reports min/max over the enabled monitors. It sits between the monitor wrapper and the register/CSR layer, all in the `i_clk` domain.

---
 rtl/process1_monitor_pkg.sv | 21 ++
 rtl/process1_monitor_eval.sv | 49 ++++
 rtl/process1_monitor_ctrl.sv | 179 +++++++++++++++++
 tb/tb_process1_monitor_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/process1_monitor_pkg.sv
// process1_monitor_pkg
//   Shared definitions for the process-monitor-1 measurement controller:
//   default geometry, the controller state encoding and a count-array type.
package process1_monitor_pkg;

    localparam int PR1_NB_MONITOR = 4;   // ring-oscillator monitors
    localparam int PR1_COUNT_W    = 16;  // count width per monitor
    localparam int PR1_TARGET_W   = 8;   // measurement target width
    localparam int PR1_TIMEOUT_W  = 16;  // timeout counter width

    typedef enum logic [2:0] {
        PR1_IDLE    = 3'd0,
        PR1_ARM     = 3'd1,
        PR1_MEASURE = 3'd2,
        PR1_CAPTURE = 3'd3,
        PR1_DONE    = 3'd4
    } pr1_ctrl_state_e;

    typedef logic [PR1_NB_MONITOR-1:0][PR1_COUNT_W-1:0] pr1_count_t;

endpackage

// File: rtl/process1_monitor_eval.sv
// process1_monitor_eval
//   Combinational evaluation of one set of monitor counts.
//   i_count      : raw per-monitor counts
//   i_mask       : monitor enable mask
//   i_thr_low    : low threshold  (alarm when count <  thr_low)
//   i_thr_high   : high threshold (alarm when count >  thr_high)
//   o_count      : counts with masked lanes forced to 0
//   o_alarm_low  : per-monitor low alarm, 0 for masked lanes
//   o_alarm_high : per-monitor high alarm, 0 for masked lanes
//   o_min/o_max  : min/max over enabled lanes only
module process1_monitor_eval
    import process1_monitor_pkg::*;
#(
    parameter int NB_MONITOR = PR1_NB_MONITOR,
    parameter int COUNT_W    = PR1_COUNT_W
) (
    input  logic [NB_MONITOR-1:0][COUNT_W-1:0] i_count,
    input  logic [NB_MONITOR-1:0]              i_mask,
    input  logic [COUNT_W-1:0]                 i_thr_low,
    input  logic [COUNT_W-1:0]                 i_thr_high,
    output logic [NB_MONITOR-1:0][COUNT_W-1:0] o_count,
    output logic [NB_MONITOR-1:0]              o_alarm_low,
    output logic [NB_MONITOR-1:0]              o_alarm_high,
    output logic [COUNT_W-1:0]                 o_min,
    output logic [COUNT_W-1:0]                 o_max
);

    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        o_count      = '0;
        o_alarm_low  = '0;
        o_alarm_high = '0;
        // A masked lane behaves as all-ones for min and zero for max, so it
        // can never win either reduction.
        o_min        = '1;
        o_max        = '0;
        for (int i = 0; i < NB_MONITOR; i++) begin
            if (i_mask[i]) begin
                o_count[i]      = i_count[i];
                o_alarm_low[i]  = (i_count[i] < i_thr_low);
                o_alarm_high[i] = (i_count[i] > i_thr_high);
                if (i_count[i] < o_min) o_min = i_count[i];
                if (i_count[i] > o_max) o_max = i_count[i];
            end
        end
    end

endmodule

// File: rtl/process1_monitor_ctrl.sv
// process1_monitor_ctrl
//   Sequences one measurement of process monitor 1: arms the monitor, waits
//   for a fresh valid, captures and evaluates the counts, or gives up after
//   a programmable cycle budget.
//   Inputs : i_clk, i_rst (sync, active-high), i_start, i_target, i_use_ro,
//            i_timeout (0 = no timeout), i_thr_low, i_thr_high,
//            i_pm_valid, i_pm_count
//   Outputs: o_pm_enable/o_pm_target/o_pm_use_ro (to monitor),
//            o_busy, o_done (1-cycle pulse), o_timeout (sticky per run),
//            o_count, o_alarm_low, o_alarm_high, o_min, o_max
module process1_monitor_ctrl
    import process1_monitor_pkg::*;
#(
    parameter int NB_MONITOR = PR1_NB_MONITOR,
    parameter int COUNT_W    = PR1_COUNT_W,
    parameter int TARGET_W   = PR1_TARGET_W,
    parameter int TIMEOUT_W  = PR1_TIMEOUT_W
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_start,
    input  logic [TARGET_W-1:0]                i_target,
    input  logic [NB_MONITOR-1:0]              i_use_ro,
    input  logic [TIMEOUT_W-1:0]               i_timeout,
    input  logic [COUNT_W-1:0]                 i_thr_low,
    input  logic [COUNT_W-1:0]                 i_thr_high,
    output logic                               o_pm_enable,
    output logic [TARGET_W-1:0]                o_pm_target,
    output logic [NB_MONITOR-1:0]              o_pm_use_ro,
    input  logic                               i_pm_valid,
    input  logic [NB_MONITOR-1:0][COUNT_W-1:0] i_pm_count,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_timeout,
    output logic [NB_MONITOR-1:0][COUNT_W-1:0] o_count,
    output logic [NB_MONITOR-1:0]              o_alarm_low,
    output logic [NB_MONITOR-1:0]              o_alarm_high,
    output logic [COUNT_W-1:0]                 o_min,
    output logic [COUNT_W-1:0]                 o_max
);

    pr1_ctrl_state_e state_q, state_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
    logic                 expire, start_accept, timeout_hit;

    logic [TARGET_W-1:0]   target_q;
    logic [NB_MONITOR-1:0] use_ro_q;
    logic [COUNT_W-1:0]    thr_low_q, thr_high_q;
    logic                  busy_q, enable_q, done_q, timeout_q;

    logic [NB_MONITOR-1:0][COUNT_W-1:0] count_q, eval_count;
    logic [NB_MONITOR-1:0]              alarm_low_q, alarm_high_q;
    logic [NB_MONITOR-1:0]              eval_alarm_low, eval_alarm_high;
    logic [COUNT_W-1:0]                 min_q, max_q, eval_min, eval_max;

    process1_monitor_eval #(
        .NB_MONITOR (NB_MONITOR),
        .COUNT_W    (COUNT_W)
    ) u_eval (
        .i_count      (i_pm_count),
        .i_mask       (use_ro_q),
        .i_thr_low    (thr_low_q),
        .i_thr_high   (thr_high_q),
        .o_count      (eval_count),
        .o_alarm_low  (eval_alarm_low),
        .o_alarm_high (eval_alarm_high),
        .o_min        (eval_min),
        .o_max        (eval_max)
    );

    // tcnt_q counts completed ARM/MEASURE cycles, so the current cycle is
    // number tcnt_q+1; expiry therefore fires on exactly the N-th cycle.
    assign tcnt_inc = tcnt_q + TIMEOUT_W'(1);
    assign expire   = (i_timeout != '0) && (tcnt_inc == i_timeout);

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        start_accept = 1'b0;
        timeout_hit  = 1'b0;
        unique case (state_q)
            PR1_IDLE: begin
                tcnt_d = '0;
                if (i_start && (i_use_ro != '0)) begin
                    start_accept = 1'b1;
                    state_d      = PR1_ARM;
                end
            end
            PR1_ARM: begin
                tcnt_d = tcnt_inc;
                if (expire) begin
                    timeout_hit = 1'b1;
                    state_d     = PR1_DONE;
                end else if (!i_pm_valid) begin
                    state_d = PR1_MEASURE;
                end
            end
            PR1_MEASURE: begin
                tcnt_d = tcnt_inc;
                // A result arriving on the expiry cycle still counts.
                if (i_pm_valid) begin
                    state_d = PR1_CAPTURE;
                end else if (expire) begin
                    timeout_hit = 1'b1;
                    state_d     = PR1_DONE;
                end
            end
            PR1_CAPTURE: state_d = PR1_DONE;
            PR1_DONE:    state_d = PR1_IDLE;
            default:     state_d = PR1_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked
        // block and every register (results included) is cleared by it.
        if (i_rst) begin
            state_q      <= PR1_IDLE;
            tcnt_q       <= '0;
            target_q     <= '0;
            use_ro_q     <= '0;
            thr_low_q    <= '0;
            thr_high_q   <= '0;
            busy_q       <= 1'b0;
            enable_q     <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
            alarm_low_q  <= '0;
            alarm_high_q <= '0;
            min_q        <= '0;
            max_q        <= '0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            // Status outputs are decoded from the next state so they line up
            // with the state they describe.
            busy_q   <= (state_d != PR1_IDLE);
            enable_q <= (state_d == PR1_ARM) || (state_d == PR1_MEASURE);
            done_q   <= (state_d == PR1_DONE);

            if (start_accept) begin
                target_q   <= i_target;
                use_ro_q   <= i_use_ro;
                thr_low_q  <= i_thr_low;
                thr_high_q <= i_thr_high;
                timeout_q  <= 1'b0;
            end

            if (timeout_hit) begin
                timeout_q    <= 1'b1;
                count_q      <= '0;
                alarm_low_q  <= '0;
                alarm_high_q <= '0;
                min_q        <= '0;
                max_q        <= '0;
            end else if (state_q == PR1_CAPTURE) begin
                count_q      <= eval_count;
                alarm_low_q  <= eval_alarm_low;
                alarm_high_q <= eval_alarm_high;
                min_q        <= eval_min;
                max_q        <= eval_max;
            end
        end
    end

    assign o_pm_enable  = enable_q;
    assign o_pm_target  = target_q;
    assign o_pm_use_ro  = use_ro_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_timeout    = timeout_q;
    assign o_count      = count_q;
    assign o_alarm_low  = alarm_low_q;
    assign o_alarm_high = alarm_high_q;
    assign o_min        = min_q;
    assign o_max        = max_q;

endmodule

// File: tb/tb_process1_monitor_ctrl.sv
// tb_process1_monitor_ctrl
//   Self-checking bench for process1_monitor_ctrl: directed scenarios plus
//   randomized runs, each compared against a run-level reference model.
module tb_process1_monitor_ctrl;
    import process1_monitor_pkg::*;

    localparam int NB = PR1_NB_MONITOR;
    localparam int CW = PR1_COUNT_W;
    localparam int TW = PR1_TARGET_W;
    localparam int OW = PR1_TIMEOUT_W;

    logic                       i_clk = 1'b0;
    logic                       i_rst;
    logic                       i_start;
    logic [TW-1:0]              i_target;
    logic [NB-1:0]              i_use_ro;
    logic [OW-1:0]              i_timeout;
    logic [CW-1:0]              i_thr_low, i_thr_high;
    logic                       o_pm_enable;
    logic [TW-1:0]              o_pm_target;
    logic [NB-1:0]              o_pm_use_ro;
    logic                       i_pm_valid;
    logic [NB-1:0][CW-1:0]      i_pm_count;
    logic                       o_busy, o_done, o_timeout;
    logic [NB-1:0][CW-1:0]      o_count;
    logic [NB-1:0]              o_alarm_low, o_alarm_high;
    logic [CW-1:0]              o_min, o_max;

    process1_monitor_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_target     (i_target),
        .i_use_ro     (i_use_ro),
        .i_timeout    (i_timeout),
        .i_thr_low    (i_thr_low),
        .i_thr_high   (i_thr_high),
        .o_pm_enable  (o_pm_enable),
        .o_pm_target  (o_pm_target),
        .o_pm_use_ro  (o_pm_use_ro),
        .i_pm_valid   (i_pm_valid),
        .i_pm_count   (i_pm_count),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_count      (o_count),
        .o_alarm_low  (o_alarm_low),
        .o_alarm_high (o_alarm_high),
        .o_min        (o_min),
        .o_max        (o_max)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One measurement. Cycle k is the interval after the k-th rising edge
    // following the start edge. Valid is 1 for cycles 1..stale (stale result),
    // then 0, then 1 from cycle r onwards (r=0: never). r must be >= stale+2.
    task automatic run(input string name, input logic [NB-1:0] mask,
                       input int unsigned cnt[NB], input int unsigned tl,
                       input int unsigned th, input int unsigned tmo,
                       input int stale, input int r, input logic [TW-1:0] tgt);
        bit                 to;
        int                 exp_done, en_last;
        logic [NB*CW-1:0]   e_cnt;
        logic [NB-1:0]      e_lo, e_hi;
        logic [CW-1:0]      e_min, e_max;
        int unsigned        q[$];

        // Reference: the run lasts until either the budget of tmo cycles in
        // ARM+MEASURE is used up (valid on the final cycle wins), or valid
        // is seen, after which CAPTURE and DONE follow.
        to       = (tmo != 0) && (r == 0 || int'(tmo) < r);
        exp_done = to ? int'(tmo) + 1 : r + 2;
        en_last  = to ? int'(tmo) : r;

        e_cnt = '0; e_lo = '0; e_hi = '0; e_min = '0; e_max = '0;
        if (!to) begin
            for (int i = 0; i < NB; i++) begin
                if (mask[i]) begin
                    q.push_back(cnt[i]);
                    e_cnt[i*CW +: CW] = CW'(cnt[i]);
                    e_lo[i] = (cnt[i] < tl);
                    e_hi[i] = (cnt[i] > th);
                end
            end
            e_min = CW'(q[0]);
            e_max = CW'(q[0]);
            foreach (q[j]) begin
                if (q[j] < e_min) e_min = CW'(q[j]);
                if (q[j] > e_max) e_max = CW'(q[j]);
            end
        end

        @(negedge i_clk);
        i_start    = 1'b1;
        i_use_ro   = mask;
        i_target   = tgt;
        i_timeout  = OW'(tmo);
        i_thr_low  = CW'(tl);
        i_thr_high = CW'(th);
        i_pm_valid = 1'b0;
        for (int i = 0; i < NB; i++) i_pm_count[i] = CW'(cnt[i]);
        @(posedge i_clk);

        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge i_clk);
            // Configuration inputs are scrambled after start and a second
            // start is issued in cycle 2: all of it must be ignored.
            i_start    = (k == 2);
            i_use_ro   = NB'($urandom);
            i_target   = TW'($urandom);
            i_timeout  = OW'(tmo);
            i_thr_low  = CW'($urandom);
            i_thr_high = CW'($urandom);
            i_pm_valid = (k <= stale) || (r != 0 && k >= r);

            check({name, ".busy"},   o_busy,      k <= exp_done);
            check({name, ".enable"}, o_pm_enable, k <= en_last);
            check({name, ".done"},   o_done,      k == exp_done);
            check({name, ".target"}, o_pm_target, tgt);
            check({name, ".use_ro"}, o_pm_use_ro, mask);
            check({name, ".timeout"}, o_timeout,  (k >= exp_done) ? to : 1'b0);
            if (k >= exp_done) begin
                check({name, ".count"},      o_count,      e_cnt);
                check({name, ".alarm_low"},  o_alarm_low,  e_lo);
                check({name, ".alarm_high"}, o_alarm_high, e_hi);
                check({name, ".min"},        o_min,        e_min);
                check({name, ".max"},        o_max,        e_max);
            end
        end
        i_start    = 1'b0;
        i_pm_valid = 1'b0;
    endtask

    int unsigned c[NB];

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_target = '0; i_use_ro = '0;
        i_timeout = '0; i_thr_low = '0; i_thr_high = '0;
        i_pm_valid = 1'b0; i_pm_count = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset.busy",   o_busy, 0);
        check("reset.enable", o_pm_enable, 0);
        check("reset.done",   o_done, 0);
        check("reset.target", o_pm_target, 0);
        check("reset.use_ro", o_pm_use_ro, 0);
        check("reset.flags",  {o_timeout, o_alarm_low, o_alarm_high}, 0);
        check("reset.count",  o_count, 0);
        check("reset.minmax", {o_min, o_max}, 0);
        i_rst = 1'b0;

        // Directed scenarios.
        c = '{100, 200, 50, 300};
        run("nominal", 4'b1111, c, 60, 250, 0, 0, 4, 8'h5a);
        run("min_latency", 4'b1111, c, 60, 250, 0, 0, 2, 8'h11);
        run("stale", 4'b1011, c, 100, 200, 0, 5, 9, 8'h22);
        c = '{10, 500, 20, 30};
        run("partial", 4'b0010, c, 100, 1000, 0, 0, 3, 8'h33);
        run("timeout", 4'b1111, c, 100, 1000, 8, 0, 0, 8'h44);
        c = '{7, 8, 9, 8};
        run("thr_equal", 4'b1111, c, 8, 8, 0, 0, 3, 8'h55);
        run("timeout_tie", 4'b0110, c, 8, 8, 8, 0, 8, 8'h66);
        run("timeout_arm", 4'b1001, c, 8, 8, 5, 10, 0, 8'h77);
        run("after_to", 4'b1100, c, 9, 7, 20, 1, 4, 8'h88);

        // Reset mid-run (in MEASURE) with non-zero results held.
        @(negedge i_clk);
        i_start = 1'b1; i_use_ro = 4'b1111; i_target = 8'h99; i_timeout = '0;
        @(posedge i_clk);
        @(negedge i_clk); i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst_mid.enable_before", o_pm_enable, 1);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("rst_mid.busy",   o_busy, 0);
        check("rst_mid.enable", o_pm_enable, 0);
        check("rst_mid.count",  o_count, 0);
        check("rst_mid.minmax", {o_min, o_max}, 0);
        check("rst_mid.alarms", {o_alarm_low, o_alarm_high}, 0);
        i_rst = 1'b0;

        // Start with an all-zero mask is ignored.
        @(negedge i_clk);
        i_start = 1'b1; i_use_ro = '0;
        @(posedge i_clk);
        @(negedge i_clk); i_start = 1'b0;
        check("mask0.busy", o_busy, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check("mask0.done", {o_done, o_busy}, 0);
        end

        // Randomized runs.
        for (int n = 0; n < 40; n++) begin
            int unsigned tl, th, tmo;
            int stale, r;
            logic [NB-1:0] m;
            m  = NB'($urandom_range(1, (1 << NB) - 1));
            tl = $urandom_range(0, 1023);
            th = $urandom_range(0, 1023);
            for (int i = 0; i < NB; i++) begin
                case ($urandom_range(0, 5))
                    0:       c[i] = tl;
                    1:       c[i] = th;
                    default: c[i] = $urandom_range(0, 1023);
                endcase
            end
            stale = $urandom_range(0, 3);
            r     = ($urandom_range(0, 5) == 0) ? 0 : stale + 2 + int'($urandom_range(0, 5));
            tmo   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 14);
            if (r == 0 && tmo == 0) tmo = 6;
            run("rand", m, c, tl, th, tmo, stale, r, TW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
